// File: rtl/id_ex_alu_stage_if.sv
// Bundle of ID-side inputs, forwarding sources and EX-side outputs of the ID/EX ALU stage.
// master drives the decode/forwarding side; slave is the stage itself.
interface id_ex_alu_stage_if #(
    parameter int XLEN = 32
);
    logic            id_valid;
    logic [6:0]      id_opcode;
    logic [2:0]      id_funct3;
    logic            id_funct7_5;
    logic [4:0]      id_rs1_addr;
    logic [4:0]      id_rs2_addr;
    logic [4:0]      id_rd_addr;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic [XLEN-1:0] id_pc;
    logic            stall;
    logic            flush;
    logic            exmem_regwrite;
    logic [4:0]      exmem_rd;
    logic [XLEN-1:0] exmem_result;
    logic            memwb_regwrite;
    logic [4:0]      memwb_rd;
    logic [XLEN-1:0] memwb_result;
    logic            ex_valid;
    logic [3:0]      ex_alu_sel;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] ex_rs2_fwd;
    logic [4:0]      ex_rd_addr;
    logic            ex_regwrite;
    logic            ex_memread;
    logic            ex_memwrite;
    logic            ex_branch;
    logic            ex_illegal;
    logic            load_use_hazard;

    modport master (
        output id_valid, id_opcode, id_funct3, id_funct7_5, id_rs1_addr, id_rs2_addr,
               id_rd_addr, id_rs1_data, id_rs2_data, id_imm, id_pc, stall, flush,
               exmem_regwrite, exmem_rd, exmem_result, memwb_regwrite, memwb_rd, memwb_result,
        input  ex_valid, ex_alu_sel, alu_a, alu_b, ex_rs2_fwd, ex_rd_addr, ex_regwrite,
               ex_memread, ex_memwrite, ex_branch, ex_illegal, load_use_hazard
    );

    modport slave (
        input  id_valid, id_opcode, id_funct3, id_funct7_5, id_rs1_addr, id_rs2_addr,
               id_rd_addr, id_rs1_data, id_rs2_data, id_imm, id_pc, stall, flush,
               exmem_regwrite, exmem_rd, exmem_result, memwb_regwrite, memwb_rd, memwb_result,
        output ex_valid, ex_alu_sel, alu_a, alu_b, ex_rs2_fwd, ex_rd_addr, ex_regwrite,
               ex_memread, ex_memwrite, ex_branch, ex_illegal, load_use_hazard
    );
endinterface

// File: rtl/id_ex_alu_stage.sv
// ID/EX pipeline register in front of the ALU: decodes the ALU select, picks operands,
// forwards from EX/MEM and MEM/WB, and flags load-use hazards back to the front end.
module id_ex_alu_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    id_ex_alu_stage_if.slave bus
);
    localparam logic [3:0] SEL_ADD  = 4'b0000;
    localparam logic [3:0] SEL_SUB  = 4'b0001;
    localparam logic [3:0] SEL_AND  = 4'b0010;
    localparam logic [3:0] SEL_OR   = 4'b0011;
    localparam logic [3:0] SEL_XOR  = 4'b0100;
    localparam logic [3:0] SEL_SLL  = 4'b0101;
    localparam logic [3:0] SEL_SRL  = 4'b0110;
    localparam logic [3:0] SEL_SRA  = 4'b0111;
    localparam logic [3:0] SEL_SLT  = 4'b1000;
    localparam logic [3:0] SEL_SLTU = 4'b1001;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [1:0] {A_RS1 = 2'b00, A_PC = 2'b01, A_ZERO = 2'b10} a_src_e;
    typedef enum logic [1:0] {B_RS2 = 2'b00, B_IMM = 2'b01, B_FOUR = 2'b10} b_src_e;

    logic [3:0]      arith_sel_s;
    logic [3:0]      dec_sel_s;
    a_src_e          dec_a_s;
    b_src_e          dec_b_s;
    logic            dec_regwrite_s, dec_memread_s, dec_memwrite_s, dec_branch_s;
    logic            dec_illegal_s, dec_uses_rs1_s, dec_uses_rs2_s;

    logic            ex_valid_r;
    logic [3:0]      ex_alu_sel_r;
    a_src_e          ex_a_src_r;
    b_src_e          ex_b_src_r;
    logic            ex_regwrite_r, ex_memread_r, ex_memwrite_r, ex_branch_r, ex_illegal_r;
    logic            ex_uses_rs1_r, ex_uses_rs2_r;
    logic [4:0]      ex_rs1_addr_r, ex_rs2_addr_r, ex_rd_addr_r;
    logic [XLEN-1:0] ex_rs1_data_r, ex_rs2_data_r, ex_imm_r, ex_pc_r;

    logic [XLEN-1:0] fwd_rs1_s, fwd_rs2_s, alu_a_s, alu_b_s;
    logic            hazard_s;

    // Shared R/I-type funct3 table; funct7[5] selects SUB only for register-register ops
    always_comb begin
        arith_sel_s = SEL_ADD;
        case (bus.id_funct3)
            3'b000:  arith_sel_s = (bus.id_funct7_5 && (bus.id_opcode == OPC_OP)) ? SEL_SUB : SEL_ADD;
            3'b001:  arith_sel_s = SEL_SLL;
            3'b010:  arith_sel_s = SEL_SLT;
            3'b011:  arith_sel_s = SEL_SLTU;
            3'b100:  arith_sel_s = SEL_XOR;
            3'b101:  arith_sel_s = bus.id_funct7_5 ? SEL_SRA : SEL_SRL;
            3'b110:  arith_sel_s = SEL_OR;
            3'b111:  arith_sel_s = SEL_AND;
            default: arith_sel_s = SEL_ADD;
        endcase
    end

    // Opcode decode into select, operand sources, control flags and source usage
    always_comb begin
        dec_sel_s      = SEL_ADD;
        dec_a_s        = A_RS1;
        dec_b_s        = B_RS2;
        dec_regwrite_s = 1'b0;
        dec_memread_s  = 1'b0;
        dec_memwrite_s = 1'b0;
        dec_branch_s   = 1'b0;
        dec_illegal_s  = 1'b0;
        dec_uses_rs1_s = 1'b0;
        dec_uses_rs2_s = 1'b0;
        case (bus.id_opcode)
            OPC_OP: begin
                dec_sel_s = arith_sel_s; dec_regwrite_s = 1'b1;
                dec_uses_rs1_s = 1'b1; dec_uses_rs2_s = 1'b1;
            end
            OPC_OPIMM: begin
                dec_sel_s = arith_sel_s; dec_b_s = B_IMM; dec_regwrite_s = 1'b1;
                dec_uses_rs1_s = 1'b1;
            end
            OPC_LOAD: begin
                dec_b_s = B_IMM; dec_regwrite_s = 1'b1; dec_memread_s = 1'b1;
                dec_uses_rs1_s = 1'b1;
            end
            OPC_STORE: begin
                dec_b_s = B_IMM; dec_memwrite_s = 1'b1;
                dec_uses_rs1_s = 1'b1; dec_uses_rs2_s = 1'b1;
            end
            OPC_BRANCH: begin
                case (bus.id_funct3)
                    3'b000, 3'b001: dec_sel_s = SEL_SUB;
                    3'b100, 3'b101: dec_sel_s = SEL_SLT;
                    3'b110, 3'b111: dec_sel_s = SEL_SLTU;
                    default:        dec_sel_s = SEL_ADD;
                endcase
                dec_branch_s = 1'b1; dec_uses_rs1_s = 1'b1; dec_uses_rs2_s = 1'b1;
            end
            OPC_LUI: begin
                dec_a_s = A_ZERO; dec_b_s = B_IMM; dec_regwrite_s = 1'b1;
            end
            OPC_AUIPC: begin
                dec_a_s = A_PC; dec_b_s = B_IMM; dec_regwrite_s = 1'b1;
            end
            OPC_JAL: begin
                dec_a_s = A_PC; dec_b_s = B_FOUR; dec_regwrite_s = 1'b1;
            end
            OPC_JALR: begin
                dec_a_s = A_PC; dec_b_s = B_FOUR; dec_regwrite_s = 1'b1;
                dec_uses_rs1_s = 1'b1;
            end
            default: dec_illegal_s = 1'b1;
        endcase
    end

    // Pipeline register: flush beats stall; invalid instructions carry no side effects
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || bus.flush) begin
            if (!rst_n) ex_pc_r <= RESET_PC;
            else        ex_pc_r <= {XLEN{1'b0}};
            ex_valid_r    <= 1'b0;
            ex_alu_sel_r  <= SEL_ADD;
            ex_a_src_r    <= A_RS1;
            ex_b_src_r    <= B_RS2;
            ex_regwrite_r <= 1'b0;
            ex_memread_r  <= 1'b0;
            ex_memwrite_r <= 1'b0;
            ex_branch_r   <= 1'b0;
            ex_illegal_r  <= 1'b0;
            ex_uses_rs1_r <= 1'b0;
            ex_uses_rs2_r <= 1'b0;
            ex_rs1_addr_r <= 5'd0;
            ex_rs2_addr_r <= 5'd0;
            ex_rd_addr_r  <= 5'd0;
            ex_rs1_data_r <= {XLEN{1'b0}};
            ex_rs2_data_r <= {XLEN{1'b0}};
            ex_imm_r      <= {XLEN{1'b0}};
        end else if (bus.stall) begin
            ex_valid_r <= ex_valid_r;
        end else begin
            ex_valid_r    <= bus.id_valid;
            ex_alu_sel_r  <= dec_sel_s;
            ex_a_src_r    <= dec_a_s;
            ex_b_src_r    <= dec_b_s;
            ex_regwrite_r <= bus.id_valid & dec_regwrite_s;
            ex_memread_r  <= bus.id_valid & dec_memread_s;
            ex_memwrite_r <= bus.id_valid & dec_memwrite_s;
            ex_branch_r   <= bus.id_valid & dec_branch_s;
            ex_illegal_r  <= bus.id_valid & dec_illegal_s;
            ex_uses_rs1_r <= dec_uses_rs1_s;
            ex_uses_rs2_r <= dec_uses_rs2_s;
            ex_rs1_addr_r <= bus.id_rs1_addr;
            ex_rs2_addr_r <= bus.id_rs2_addr;
            ex_rd_addr_r  <= bus.id_rd_addr;
            ex_rs1_data_r <= bus.id_rs1_data;
            ex_rs2_data_r <= bus.id_rs2_data;
            ex_imm_r      <= bus.id_imm;
            ex_pc_r       <= bus.id_pc;
        end
    end

    // Forwarding muxes: EX/MEM beats MEM/WB, x0 and unused sources never forward
    always_comb begin
        fwd_rs1_s = ex_rs1_data_r;
        fwd_rs2_s = ex_rs2_data_r;
        if (ex_valid_r && ex_uses_rs1_r && (ex_rs1_addr_r != 5'd0)) begin
            if (bus.exmem_regwrite && (bus.exmem_rd == ex_rs1_addr_r))      fwd_rs1_s = bus.exmem_result;
            else if (bus.memwb_regwrite && (bus.memwb_rd == ex_rs1_addr_r)) fwd_rs1_s = bus.memwb_result;
            else                                                            fwd_rs1_s = ex_rs1_data_r;
        end else begin
            fwd_rs1_s = ex_rs1_data_r;
        end
        if (ex_valid_r && ex_uses_rs2_r && (ex_rs2_addr_r != 5'd0)) begin
            if (bus.exmem_regwrite && (bus.exmem_rd == ex_rs2_addr_r))      fwd_rs2_s = bus.exmem_result;
            else if (bus.memwb_regwrite && (bus.memwb_rd == ex_rs2_addr_r)) fwd_rs2_s = bus.memwb_result;
            else                                                            fwd_rs2_s = ex_rs2_data_r;
        end else begin
            fwd_rs2_s = ex_rs2_data_r;
        end
    end

    // Operand source selection
    always_comb begin
        alu_a_s = fwd_rs1_s;
        alu_b_s = fwd_rs2_s;
        case (ex_a_src_r)
            A_RS1:   alu_a_s = fwd_rs1_s;
            A_PC:    alu_a_s = ex_pc_r;
            A_ZERO:  alu_a_s = {XLEN{1'b0}};
            default: alu_a_s = fwd_rs1_s;
        endcase
        case (ex_b_src_r)
            B_RS2:   alu_b_s = fwd_rs2_s;
            B_IMM:   alu_b_s = ex_imm_r;
            B_FOUR:  alu_b_s = {{(XLEN-3){1'b0}}, 3'b100};
            default: alu_b_s = fwd_rs2_s;
        endcase
    end

    // Load-use detection against the instruction currently in decode
    always_comb begin
        hazard_s = 1'b0;
        if (ex_valid_r && ex_memread_r && (ex_rd_addr_r != 5'd0) && bus.id_valid) begin
            hazard_s = (dec_uses_rs1_s && (bus.id_rs1_addr == ex_rd_addr_r)) ||
                       (dec_uses_rs2_s && (bus.id_rs2_addr == ex_rd_addr_r));
        end else begin
            hazard_s = 1'b0;
        end
    end

    assign bus.ex_valid        = ex_valid_r;
    assign bus.ex_alu_sel      = ex_alu_sel_r;
    assign bus.alu_a           = alu_a_s;
    assign bus.alu_b           = alu_b_s;
    assign bus.ex_rs2_fwd      = fwd_rs2_s;
    assign bus.ex_rd_addr      = ex_rd_addr_r;
    assign bus.ex_regwrite     = ex_regwrite_r;
    assign bus.ex_memread      = ex_memread_r;
    assign bus.ex_memwrite     = ex_memwrite_r;
    assign bus.ex_branch       = ex_branch_r;
    assign bus.ex_illegal      = ex_illegal_r;
    assign bus.load_use_hazard = hazard_s;
endmodule

// File: tb/tb_id_ex_alu_stage.sv
// Self-checking bench for id_ex_alu_stage: directed scenarios plus randomized traffic
// compared against an instruction-level reference model of the EX stage.
module tb_id_ex_alu_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    id_ex_alu_stage_if #(.XLEN(32)) bus();

    id_ex_alu_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] OP = 7'b0110011, OPI = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011;
    localparam logic [6:0] BR = 7'b1100011, LUI = 7'b0110111, AUIPC = 7'b0010111;
    localparam logic [6:0] JAL = 7'b1101111, JALR = 7'b1100111;

    typedef struct {
        logic        valid;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f75;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm, pc;
    } instr_t;

    typedef struct {
        logic        valid;
        logic [3:0]  sel;
        logic [31:0] a, b, rs2f;
        logic [4:0]  rd;
        logic [4:0]  flags;  // regwrite, memread, memwrite, branch, illegal
    } exp_t;

    instr_t ex_m;

    // ALU op numbering: ADD SUB AND OR XOR SLL SRL SRA SLT SLTU = 0..9
    function automatic logic [3:0] m_sel(input logic [6:0] op, input logic [2:0] f3, input logic f75);
        logic [3:0] base [8];
        base = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
        if (op == OP || op == OPI) begin
            if (f3 == 3'd0 && op == OP && f75) return 4'd1;
            if (f3 == 3'd5 && f75)             return 4'd7;
            return base[f3];
        end
        if (op == BR) begin
            if (f3 < 3'd2) return 4'd1;
            if (f3 < 3'd4) return 4'd0;
            if (f3 < 3'd6) return 4'd8;
            return 4'd9;
        end
        return 4'd0;
    endfunction

    function automatic bit m_legal(input logic [6:0] op);
        return op inside {OP, OPI, LD, ST, BR, LUI, AUIPC, JAL, JALR};
    endfunction
    function automatic bit m_u1(input logic [6:0] op);
        return op inside {OP, OPI, LD, ST, BR, JALR};
    endfunction
    function automatic bit m_u2(input logic [6:0] op);
        return op inside {OP, ST, BR};
    endfunction

    function automatic logic [31:0] m_fwd(input instr_t i, input logic [4:0] addr,
                                          input logic [31:0] raw, input bit used);
        if (!i.valid || !used || addr == 5'd0) return raw;
        if (bus.exmem_regwrite && bus.exmem_rd == addr) return bus.exmem_result;
        if (bus.memwb_regwrite && bus.memwb_rd == addr) return bus.memwb_result;
        return raw;
    endfunction

    function automatic exp_t m_expect(input instr_t i);
        exp_t e;
        logic [31:0] f1, f2;
        f1 = m_fwd(i, i.rs1, i.d1, m_u1(i.op));
        f2 = m_fwd(i, i.rs2, i.d2, m_u2(i.op));
        e.valid = i.valid;
        e.sel   = m_sel(i.op, i.f3, i.f75);
        e.rd    = i.rd;
        e.rs2f  = f2;
        e.flags = {i.valid && (i.op inside {OP, OPI, LD, LUI, AUIPC, JAL, JALR}),
                   i.valid && i.op == LD, i.valid && i.op == ST, i.valid && i.op == BR,
                   i.valid && !m_legal(i.op)};
        if (i.op == LUI) e.a = 32'd0;
        else if (i.op inside {AUIPC, JAL, JALR}) e.a = i.pc;
        else e.a = f1;
        if (i.op inside {OP, BR}) e.b = f2;
        else if (i.op inside {JAL, JALR}) e.b = 32'd4;
        else if (m_legal(i.op)) e.b = i.imm;
        else e.b = i.d2;
        return e;
    endfunction

    function automatic bit m_hazard();
        if (!(ex_m.valid && ex_m.op == LD && ex_m.rd != 5'd0 && bus.id_valid)) return 1'b0;
        return (m_u1(bus.id_opcode) && bus.id_rs1_addr == ex_m.rd) ||
               (m_u2(bus.id_opcode) && bus.id_rs2_addr == ex_m.rd);
    endfunction

    // A bubble looks like "add x0,x0,x0" with zero data and no valid bit
    task automatic model_bubble();
        ex_m = '{valid: 1'b0, op: OP, f3: 3'd0, f75: 1'b0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0,
                 d1: 32'd0, d2: 32'd0, imm: 32'd0, pc: 32'd0};
    endtask

    task automatic tick();
        if (bus.flush) model_bubble();
        else if (!bus.stall)
            ex_m = '{valid: bus.id_valid, op: bus.id_opcode, f3: bus.id_funct3, f75: bus.id_funct7_5,
                     rs1: bus.id_rs1_addr, rs2: bus.id_rs2_addr, rd: bus.id_rd_addr,
                     d1: bus.id_rs1_data, d2: bus.id_rs2_data, imm: bus.id_imm, pc: bus.id_pc};
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] imm, input logic [31:0] pc);
        bus.id_valid = 1'b1; bus.id_opcode = op; bus.id_funct3 = f3; bus.id_funct7_5 = f75;
        bus.id_rs1_addr = rs1; bus.id_rs2_addr = rs2; bus.id_rd_addr = rd;
        bus.id_rs1_data = d1; bus.id_rs2_data = d2; bus.id_imm = imm; bus.id_pc = pc;
    endtask

    task automatic clear_fwd();
        bus.exmem_regwrite = 1'b0; bus.exmem_rd = 5'd0; bus.exmem_result = 32'd0;
        bus.memwb_regwrite = 1'b0; bus.memwb_rd = 5'd0; bus.memwb_result = 32'd0;
    endtask

    task automatic test_reset();
        if (bus.ex_valid !== 1'b0 || bus.ex_alu_sel !== 4'd0 || bus.alu_a !== 32'd0 || bus.alu_b !== 32'd0) begin
            errors++;
            $display("FAIL reset_initial: valid=%b sel=%h a=%h b=%h, want 0 0 0 0",
                     bus.ex_valid, bus.ex_alu_sel, bus.alu_a, bus.alu_b);
        end
        checks++;
        set_id(LD, 3'd2, 1'b0, 5'd3, 5'd4, 5'd9, 32'h1111_2222, 32'h3333_4444, 32'h10, 32'h40);
        tick();
        set_id(OP, 3'd0, 1'b0, 5'd9, 5'd1, 5'd2, 32'd1, 32'd2, 32'd0, 32'd0);
        bus.exmem_regwrite = 1'b1; bus.exmem_rd = 5'd3; bus.exmem_result = 32'hDEAD_0001;
        #2;
        rst_n = 1'b0;
        #1;
        model_bubble();
        if (bus.ex_valid !== 1'b0 || bus.ex_alu_sel !== 4'd0 || bus.alu_a !== 32'd0 ||
            bus.alu_b !== 32'd0 || bus.load_use_hazard !== 1'b0 || bus.ex_memread !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: valid=%b sel=%h a=%h b=%h hz=%b mr=%b, want all 0",
                     bus.ex_valid, bus.ex_alu_sel, bus.alu_a, bus.alu_b, bus.load_use_hazard, bus.ex_memread);
        end
        checks++;
        clear_fwd();
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_rtype();
        set_id(OP, 3'd0, 1'b1, 5'd1, 5'd2, 5'd3, 32'h0FFF_1256, 32'h0011_FF23, 32'd0, 32'd0);
        tick();
        if (bus.ex_alu_sel !== 4'b0001 || bus.alu_a !== 32'h0FFF_1256 ||
            bus.alu_b !== 32'h0011_FF23 || bus.ex_regwrite !== 1'b1 || bus.ex_valid !== 1'b1) begin
            errors++;
            $display("FAIL rtype_sub: sel=%h a=%h b=%h rw=%b v=%b, want 1 0fff1256 0011ff23 1 1",
                     bus.ex_alu_sel, bus.alu_a, bus.alu_b, bus.ex_regwrite, bus.ex_valid);
        end
        checks++;
    endtask

    task automatic test_imm();
        set_id(OPI, 3'd5, 1'b1, 5'd4, 5'd0, 5'd6, 32'h8000_0000, 32'h0, 32'd5, 32'd0);
        tick();
        if (bus.ex_alu_sel !== 4'b0111 || bus.alu_b !== 32'd5) begin
            errors++;
            $display("FAIL imm_srai: sel=%h b=%h, want 7 00000005", bus.ex_alu_sel, bus.alu_b);
        end
        checks++;
        set_id(AUIPC, 3'd0, 1'b0, 5'd0, 5'd0, 5'd6, 32'h0, 32'h0, 32'h1000, 32'h100);
        tick();
        if (bus.ex_alu_sel !== 4'b0000 || bus.alu_a !== 32'h100 || bus.alu_b !== 32'h1000) begin
            errors++;
            $display("FAIL imm_auipc: sel=%h a=%h b=%h, want 0 00000100 00001000",
                     bus.ex_alu_sel, bus.alu_a, bus.alu_b);
        end
        checks++;
        set_id(7'b0000000, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'h5, 32'h6, 32'h7, 32'h8);
        tick();
        if (bus.ex_illegal !== 1'b1 || bus.ex_regwrite !== 1'b0 || bus.ex_alu_sel !== 4'd0) begin
            errors++;
            $display("FAIL imm_illegal: ill=%b rw=%b sel=%h, want 1 0 0",
                     bus.ex_illegal, bus.ex_regwrite, bus.ex_alu_sel);
        end
        checks++;
    endtask

    task automatic test_forwarding();
        set_id(OP, 3'd0, 1'b0, 5'd5, 5'd6, 5'd8, 32'h0000_1111, 32'h0000_2222, 32'd0, 32'd0);
        tick();
        bus.exmem_regwrite = 1'b1; bus.exmem_rd = 5'd5; bus.exmem_result = 32'h0000_AAAA;
        bus.memwb_regwrite = 1'b1; bus.memwb_rd = 5'd5; bus.memwb_result = 32'h0000_BBBB;
        #1;
        if (bus.alu_a !== 32'h0000_AAAA) begin
            errors++;
            $display("FAIL fwd_exmem_prio: alu_a=%h, want 0000aaaa", bus.alu_a);
        end
        checks++;
        bus.exmem_regwrite = 1'b0;
        #1;
        if (bus.alu_a !== 32'h0000_BBBB) begin
            errors++;
            $display("FAIL fwd_memwb: alu_a=%h, want 0000bbbb", bus.alu_a);
        end
        checks++;
        clear_fwd();
        set_id(OP, 3'd0, 1'b0, 5'd0, 5'd6, 5'd8, 32'h1234_5678, 32'h0000_2222, 32'd0, 32'd0);
        tick();
        bus.exmem_regwrite = 1'b1; bus.exmem_rd = 5'd0; bus.exmem_result = 32'h0000_AAAA;
        #1;
        if (bus.alu_a !== 32'h1234_5678) begin
            errors++;
            $display("FAIL fwd_x0: alu_a=%h, want 12345678", bus.alu_a);
        end
        checks++;
        clear_fwd();
    endtask

    task automatic test_stall_flush();
        exp_t e;
        set_id(OP, 3'd6, 1'b0, 5'd10, 5'd11, 5'd12, 32'hA5A5_0000, 32'h0000_5A5A, 32'd0, 32'd0);
        tick();
        bus.stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_id(OPI, 3'($urandom_range(0, 7)), 1'b0, 5'd1, 5'd2, 5'd3, $urandom, $urandom, $urandom, $urandom);
            tick();
            e = m_expect(ex_m);
            if (bus.ex_alu_sel !== 4'b0011 || bus.alu_a !== 32'hA5A5_0000 || bus.alu_b !== 32'h0000_5A5A ||
                bus.ex_valid !== e.valid || bus.ex_rd_addr !== 5'd12) begin
                errors++;
                $display("FAIL stall_hold[%0d]: sel=%h a=%h b=%h rd=%0d, want 3 a5a50000 00005a5a 12",
                         k, bus.ex_alu_sel, bus.alu_a, bus.alu_b, bus.ex_rd_addr);
            end
            checks++;
        end
        bus.flush = 1'b1;
        tick();
        if (bus.ex_valid !== 1'b0 || bus.ex_alu_sel !== 4'd0 || bus.ex_regwrite !== 1'b0) begin
            errors++;
            $display("FAIL flush_over_stall: v=%b sel=%h rw=%b, want 0 0 0",
                     bus.ex_valid, bus.ex_alu_sel, bus.ex_regwrite);
        end
        checks++;
        bus.flush = 1'b0; bus.stall = 1'b0;
    endtask

    task automatic test_load_use();
        set_id(LD, 3'd2, 1'b0, 5'd1, 5'd0, 5'd7, 32'h100, 32'h0, 32'h4, 32'h0);
        tick();
        set_id(OP, 3'd0, 1'b0, 5'd3, 5'd7, 5'd9, 32'h0, 32'h0, 32'h0, 32'h0);
        #1;
        if (bus.load_use_hazard !== 1'b1) begin
            errors++;
            $display("FAIL loaduse_rs2: hazard=%b, want 1", bus.load_use_hazard);
        end
        checks++;
        set_id(LUI, 3'd0, 1'b0, 5'd7, 5'd7, 5'd9, 32'h0, 32'h0, 32'h0, 32'h0);
        #1;
        if (bus.load_use_hazard !== 1'b0) begin
            errors++;
            $display("FAIL loaduse_lui: hazard=%b, want 0", bus.load_use_hazard);
        end
        checks++;
        set_id(LD, 3'd2, 1'b0, 5'd1, 5'd0, 5'd0, 32'h100, 32'h0, 32'h4, 32'h0);
        tick();
        set_id(OP, 3'd0, 1'b0, 5'd0, 5'd0, 5'd9, 32'h0, 32'h0, 32'h0, 32'h0);
        #1;
        if (bus.load_use_hazard !== 1'b0) begin
            errors++;
            $display("FAIL loaduse_rd0: hazard=%b, want 0", bus.load_use_hazard);
        end
        checks++;
    endtask

    task automatic rand_inputs();
        logic [6:0] ops [9];
        logic [2:0] f3;
        ops = '{OP, OPI, LD, ST, BR, LUI, AUIPC, JAL, JALR};
        bus.id_opcode = ops[$urandom_range(0, 8)];
        f3 = 3'($urandom_range(0, 7));
        if (bus.id_opcode == BR && (f3 == 3'd2 || f3 == 3'd3)) f3 = 3'd0;
        bus.id_funct3   = f3;
        bus.id_funct7_5 = 1'($urandom_range(0, 1));
        bus.id_valid    = ($urandom_range(0, 9) != 0);
        bus.id_rs1_addr = 5'($urandom_range(0, 7));
        bus.id_rs2_addr = 5'($urandom_range(0, 7));
        bus.id_rd_addr  = 5'($urandom_range(0, 7));
        bus.id_rs1_data = $urandom; bus.id_rs2_data = $urandom;
        bus.id_imm = $urandom; bus.id_pc = $urandom;
        bus.stall = ($urandom_range(0, 9) == 0);
        bus.flush = ($urandom_range(0, 11) == 0);
        bus.exmem_regwrite = 1'($urandom_range(0, 1)); bus.exmem_rd = 5'($urandom_range(0, 7));
        bus.exmem_result = $urandom;
        bus.memwb_regwrite = 1'($urandom_range(0, 1)); bus.memwb_rd = 5'($urandom_range(0, 7));
        bus.memwb_result = $urandom;
    endtask

    task automatic test_random();
        exp_t e;
        logic [4:0] got_flags;
        rand_inputs();
        for (int n = 0; n < 400; n++) begin
            tick();
            rand_inputs();
            #1;
            e = m_expect(ex_m);
            got_flags = {bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite, bus.ex_branch, bus.ex_illegal};
            if (bus.ex_valid !== e.valid || bus.ex_alu_sel !== e.sel || bus.ex_rd_addr !== e.rd) begin
                errors++;
                $display("FAIL rand_ctrl[%0d]: v=%b sel=%h rd=%0d, want %b %h %0d",
                         n, bus.ex_valid, bus.ex_alu_sel, bus.ex_rd_addr, e.valid, e.sel, e.rd);
            end
            checks++;
            if (got_flags !== e.flags) begin
                errors++;
                $display("FAIL rand_flags[%0d]: flags=%b, want %b", n, got_flags, e.flags);
            end
            checks++;
            if (bus.alu_a !== e.a || bus.alu_b !== e.b || bus.ex_rs2_fwd !== e.rs2f) begin
                errors++;
                $display("FAIL rand_operands[%0d]: a=%h b=%h rs2f=%h, want %h %h %h",
                         n, bus.alu_a, bus.alu_b, bus.ex_rs2_fwd, e.a, e.b, e.rs2f);
            end
            checks++;
            if (bus.load_use_hazard !== m_hazard()) begin
                errors++;
                $display("FAIL rand_hazard[%0d]: hazard=%b, want %b", n, bus.load_use_hazard, m_hazard());
            end
            checks++;
        end
        bus.stall = 1'b0; bus.flush = 1'b0;
        clear_fwd();
    endtask

    initial begin
        set_id(OP, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        bus.id_valid = 1'b0;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        clear_fwd();
        model_bubble();
        #12;
        test_reset();
        rst_n = 1'b1;
        test_rtype();
        test_imm();
        test_forwarding();
        test_stall_flush();
        test_load_use();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/id_ex_alu_stage.md
Name: id_ex_alu_stage

Overview:
- ID/EX pipeline stage that sits directly upstream of the ALU.
- Registers decoded instruction fields and generates the 4-bit ALU select from opcode/funct3/funct7[5].
- Selects the ALU A and B operands (register, PC, immediate, constant) and applies EX/MEM and MEM/WB forwarding.
- Detects load-use hazards and supports stall and flush.

Parameters:
- XLEN, 32, datapath width.
- RESET_PC, 32'h0000_0000, reset value of ex_pc.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- id_valid  in  1  decode stage holds a valid instruction.
- id_opcode  in  7  instr[6:0].
- id_funct3  in  3  instr[14:12].
- id_funct7_5  in  1  instr[30].
- id_rs1_addr, id_rs2_addr, id_rd_addr  in  5 each  register indices.
- id_rs1_data, id_rs2_data  in  XLEN  register file read data.
- id_imm  in  XLEN  sign-extended immediate.
- id_pc  in  XLEN  instruction PC.
- stall  in  1  hold the stage contents.
- flush  in  1  replace the stage contents with a bubble.
- exmem_regwrite  in  1  EX/MEM forwarding enable.
- exmem_rd  in  5  EX/MEM destination register.
- exmem_result  in  XLEN  EX/MEM forwarded value.
- memwb_regwrite  in  1  MEM/WB forwarding enable.
- memwb_rd  in  5  MEM/WB destination register.
- memwb_result  in  XLEN  MEM/WB forwarded value.
- ex_valid  out  1  EX stage holds a valid instruction.
- ex_alu_sel  out  4  ALU select (registered).
- alu_a, alu_b  out  XLEN  ALU operands after forwarding (combinational from registered state).
- ex_rs2_fwd  out  XLEN  forwarded rs2 value, used as store data.
- ex_rd_addr  out  5  destination register.
- ex_regwrite, ex_memread, ex_memwrite, ex_branch  out  1 each  control flags.
- ex_illegal  out  1  unsupported opcode.
- load_use_hazard  out  1  combinational stall request to the front end.

Behaviour:
- ALU select encoding:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR
  - 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT, 1001 SLTU
  - 1010–1111 are never generated.
- Decode by opcode:
  - OP 0110011 (B=rs2):
    - f3 000 → f7_5 ? SUB : ADD; 001 → SLL; 010 → SLT; 011 → SLTU
    - 100 → XOR; 101 → f7_5 ? SRA : SRL; 110 → OR; 111 → AND
  - OP-IMM 0010011 (B=imm): same table, except f3 000 is always ADD.
  - LOAD 0000011: ADD, A=rs1, B=imm, memread=1.
  - STORE 0100011: ADD, A=rs1, B=imm, memwrite=1, regwrite=0.
  - BRANCH 1100011: f3 000/001 → SUB; 100/101 → SLT; 110/111 → SLTU; B=rs2; branch=1; regwrite=0.
  - LUI 0110111: ADD, A=0, B=imm.
  - AUIPC 0010111: ADD, A=pc, B=imm.
  - JAL 1101111 / JALR 1100111: ADD, A=pc, B=4 (link value).
  - Any other opcode: ADD, regwrite=memread=memwrite=branch=0, ex_illegal=1.
- uses_rs1 is set for OP, OP-IMM, LOAD, STORE, BRANCH and JALR.
- uses_rs2 is set for OP, STORE and BRANCH.
- Update rules, evaluated at each rising clk edge, highest priority first:
  1. flush=1 → bubble: ex_valid=0, all control flags 0, sel=0000, operand registers 0. Flush wins over a simultaneous stall.
  2. stall=1 → every register holds its value.
  3. Otherwise → load the decoded fields. ex_valid=id_valid. If id_valid=0, all control flags are loaded as 0.
- Latency: one cycle from the ID inputs to ex_alu_sel and the operands.
- Forwarding, for each of rs1/rs2 and only when that source is used by the instruction in EX:
  - EX/MEM hit (exmem_regwrite && exmem_rd==addr && addr!=0) takes priority.
  - Otherwise MEM/WB hit (memwb_regwrite && memwb_rd==addr && addr!=0).
  - Otherwise the registered register-file data.
  - x0 is never forwarded.
- Forwarding does not affect PC, immediate or constant operands.
- ex_rs2_fwd always carries the forwarded rs2, independent of the B source.
- load_use_hazard = ex_valid && ex_memread && ex_rd_addr!=0 && id_valid && ((uses_rs1(id) && id_rs1_addr==ex_rd_addr) || (uses_rs2(id) && id_rs2_addr==ex_rd_addr)).
  - The hazard check is combinational and is not registered.
- Reset (rst_n low, asynchronous):
  - ex_valid=0, ex_alu_sel=0000, all control flags 0, ex_rd_addr=0, all operand registers 0, ex_pc=RESET_PC.
  - alu_a and alu_b therefore read 0 unless a forward hits; forwarding is gated by ex_valid so it reads 0 during reset.
  - Reset asserted mid-stall or mid-flush takes effect immediately.

Test Plan:
- Reset: assert rst_n=0 mid-operation → ex_valid=0, ex_alu_sel=0000, alu_a=alu_b=0, load_use_hazard=0, all asynchronously with no clock edge.
- R-type SUB: opcode 0110011, f3=000, f7_5=1, rs1_data=0x0FFF1256, rs2_data=0x0011FF23 → next cycle ex_alu_sel=0001, alu_a=0x0FFF1256, alu_b=0x0011FF23, ex_regwrite=1.
- Immediates:
  - OP-IMM f3=101, f7_5=1, imm=5 → sel=0111, alu_b=5.
  - AUIPC pc=0x100, imm=0x1000 → sel=0000, alu_a=0x100, alu_b=0x1000.
  - Opcode 0000000 → ex_illegal=1, ex_regwrite=0.
- Forwarding, EX instruction with rs1=5:
  - exmem_rd=5/0xAAAA and memwb_rd=5/0xBBBB both hitting → alu_a=0xAAAA.
  - Drop exmem_regwrite → alu_a=0xBBBB.
  - rs1=0 with exmem_rd=0 → alu_a=rs1_data.
- Stall/flush: stall held for 3 cycles while ID inputs change → outputs unchanged. Then flush and stall together → ex_valid=0, sel=0000 on the next edge.
- Load-use: EX holds LOAD with rd=7; ID holds OP with rs2=7 → load_use_hazard=1. ID holds LUI with rs1 field=7 → load_use_hazard=0. EX rd=0 → load_use_hazard=0.
